// File: rtl/instr_prefetch_queue.sv
`timescale 1ns/1ps
// Purpose: sequential instruction prefetcher with a DEPTH-entry in-order {pc, instr} FIFO and redirect flush.
// Latency: response in cycle N is visible on deq_* in cycle N+1; first request after redirect in cycle R+1.
// Backpressure: credit based; requests stop while count + outstanding == DEPTH, so the FIFO never overflows.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-low reset
//   mem_req_*           - fetch request channel (valid/ready), byte address of the instruction
//   mem_rsp_*           - in-order response channel, one 32-bit word per accepted request
//   deq_*               - head entry to decode (valid/ready), pc and instruction read combinationally
//   redirect, redirect_pc - taken branch: flush the FIFO and restart fetching at redirect_pc
//   count               - occupied FIFO entries
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req_valid,
    output logic [63:0]              mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [63:0]              deq_pc,
    output logic [31:0]              deq_instr,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [63:0]   pcq_q        [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW:0]   credit_used;
    logic          req_acc, rsp_keep, rsp_drop, deq_fire;

    // Outstanding requests hold a reserved FIFO slot, so count + outstanding is the credit in use.
    assign credit_used   = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_valid = (credit_used < DEPTH_W) && !redirect;
    assign mem_req_addr  = fetch_pc_q;
    assign req_acc       = mem_req_valid && mem_req_ready;

    // A response arriving in the redirect cycle belongs to the flushed stream and is never written.
    assign rsp_keep = mem_rsp_valid && (discard_q == '0) && !redirect;
    assign rsp_drop = mem_rsp_valid && (discard_q != '0);

    assign deq_valid = (count_q != '0);
    assign deq_pc    = fifo_pc_q[rd_ptr_q];
    assign deq_instr = fifo_instr_q[rd_ptr_q];
    assign deq_fire  = deq_valid && deq_ready;
    assign count     = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CW'(req_acc) - CW'(mem_rsp_valid);

        if (req_acc) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
            pcq_wr_d   = pcq_wr_q + 1'b1;
        end
        // The PC queue tracks every in-flight request, kept or discarded alike.
        if (mem_rsp_valid) begin
            pcq_rd_d = pcq_rd_q + 1'b1;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this edge is stale.
            discard_d  = outst_q - CW'(mem_rsp_valid);
        end else begin
            if (rsp_keep) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rsp_drop) begin
                discard_d = discard_q - 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(rsp_keep) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
                pcq_q[i]        <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (req_acc) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
            end
            if (rsp_keep) begin
                fifo_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
                fifo_instr_q[wr_ptr_q] <= mem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for instr_prefetch_queue with an in-order memory model and a queue-level reference.
// Latency: inputs change 1ns after the rising edge; the reference is compared on every falling edge.
// Backpressure: mem_req_ready and deq_ready are driven per cycle by directed and random stimulus.
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [2:0]  count;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_pc        (deq_pc),
        .deq_instr     (deq_instr),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1300_0013;
    endfunction

    // Reference: the FIFO contents as a queue, memory as a queue of tagged in-flight requests.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] mq_addr[$];
    int          mq_due[$];
    int          mq_ep[$];
    logic [63:0] fetch_exp;
    logic [63:0] stream_pc;
    int          epoch;
    int          last_due;
    int          cyc;
    int          cur_lat;
    bit          chk_en;

    bit          s_mem_rdy;
    bit          s_deq_rdy;
    bit          s_redir;
    logic [63:0] s_rpc;
    int          s_lat;

    function automatic bit exp_req_vld();
        return ((exp_q.size() + mq_addr.size()) < DEPTH) && !redirect;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mq_addr.delete();
        mq_due.delete();
        mq_ep.delete();
        fetch_exp = RESET_PC;
        stream_pc = RESET_PC;
        epoch     = 0;
        last_due  = -1;
        cyc       = 0;
    endtask

    task automatic model_update();
        bit   vld;
        ent_t e;
        int   due;
        vld = exp_req_vld();
        if (exp_q.size() != 0 && deq_ready) begin
            void'(exp_q.pop_front());
            stream_pc = stream_pc + 64'd4;
        end
        if (mem_rsp_valid && mq_addr.size() != 0) begin
            if (!redirect && mq_ep[0] == epoch) begin
                e.pc    = mq_addr[0];
                e.instr = instr_of(mq_addr[0]);
                exp_q.push_back(e);
            end
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            void'(mq_ep.pop_front());
        end
        if (redirect) begin
            exp_q.delete();
            epoch++;
            fetch_exp = redirect_pc;
            stream_pc = redirect_pc;
        end
        if (vld && mem_req_ready) begin
            due = cyc + cur_lat;
            if (due <= last_due) due = last_due + 1;
            mq_addr.push_back(fetch_exp);
            mq_due.push_back(due);
            mq_ep.push_back(epoch);
            last_due  = due;
            fetch_exp = fetch_exp + 64'd4;
        end
        cyc++;
    endtask

    task automatic drive();
        mem_req_ready = s_mem_rdy;
        deq_ready     = s_deq_rdy;
        redirect      = s_redir;
        redirect_pc   = s_rpc;
        cur_lat       = s_lat;
        if (mq_due.size() != 0 && mq_due[0] == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = instr_of(mq_addr[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        drive();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        chk_en        = 1'b0;
        rst_n         = 1'b0;
        s_redir       = 1'b0;
        redirect      = 1'b0;
        mem_rsp_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        chk_en = 1'b1;
        #1;
    endtask

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_valid", 64'(mem_req_valid), 64'(exp_req_vld()));
            if (exp_req_vld()) chk("req_addr", mem_req_addr, fetch_exp);
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("deq_valid", 64'(deq_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("deq_pc", deq_pc, exp_q[0].pc);
                chk("deq_instr", 64'(deq_instr), 64'(exp_q[0].instr));
                if (deq_ready) chk("stream_pc", deq_pc, stream_pc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        deq_ready = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; chk_en = 1'b0; cur_lat = 1;
        s_mem_rdy = 1'b1; s_deq_rdy = 1'b1; s_redir = 1'b0; s_rpc = 64'h0; s_lat = 1;

        // Streaming with 1-cycle memory.
        do_reset();
        chk("rst_req_valid", 64'(mem_req_valid), 64'd1);
        chk("rst_req_addr", mem_req_addr, 64'h0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        steps(2);
        chk("c2_deq_valid", 64'(deq_valid), 64'd1);
        chk("c2_deq_pc", deq_pc, 64'h0);
        chk("c2_deq_instr", 64'(deq_instr), 64'h1300_0013);
        step();
        chk("c3_deq_pc", deq_pc, 64'h4);
        chk("c3_deq_instr", 64'(deq_instr), 64'h1300_0017);
        step();
        chk("c4_deq_pc", deq_pc, 64'h8);
        chk("c4_count", 64'(count), 64'd1);
        steps(10);

        // Decode stalled: the FIFO fills to DEPTH and fetch stops.
        s_deq_rdy = 1'b0;
        do_reset();
        steps(10);
        chk("full_count", 64'(count), 64'd4);
        chk("full_req_valid", 64'(mem_req_valid), 64'd0);
        chk("full_deq_pc", deq_pc, 64'h0);
        s_deq_rdy = 1'b1;
        deq_ready = 1'b1;
        #1;
        step();
        chk("drain_req_addr", mem_req_addr, 64'h10);
        chk("drain_req_valid", 64'(mem_req_valid), 64'd1);
        chk("drain_pc1", deq_pc, 64'h4);
        step();
        chk("drain_pc2", deq_pc, 64'h8);
        step();
        chk("drain_pc3", deq_pc, 64'hC);
        chk("drain_instr3", 64'(deq_instr), 64'h1300_001F);
        steps(6);

        // Redirect with two stale requests in flight, latency 3.
        s_lat = 3;
        do_reset();
        steps(2);
        redirect = 1'b1; redirect_pc = 64'h100;
        #1;
        chk("redir_req_valid", 64'(mem_req_valid), 64'd0);
        step();
        chk("post_redir_addr", mem_req_addr, 64'h100);
        chk("post_redir_count", 64'(count), 64'd0);
        chk("post_redir_deq_valid", 64'(deq_valid), 64'd0);
        steps(4);
        chk("redir_first_pc", deq_pc, 64'h100);
        chk("redir_first_instr", 64'(deq_instr), 64'h1300_0113);
        steps(6);

        // Redirect coincident with a response and a dequeue, latency 2.
        s_lat = 2;
        do_reset();
        steps(3);
        chk("coinc_deq_pc", deq_pc, 64'h0);
        redirect = 1'b1; redirect_pc = 64'h200;
        #1;
        chk("coinc_deq_valid", 64'(deq_valid), 64'd1);
        step();
        chk("coinc_addr", mem_req_addr, 64'h200);
        chk("coinc_count", 64'(count), 64'd0);
        step();
        chk("coinc_c5_deq_valid", 64'(deq_valid), 64'd0);
        steps(2);
        chk("coinc_first_pc", deq_pc, 64'h200);
        step();
        chk("coinc_second_pc", deq_pc, 64'h204);
        steps(4);

        // Asynchronous reset with three entries held.
        s_lat = 1; s_deq_rdy = 1'b0;
        do_reset();
        steps(4);
        chk("pre_arst_count", 64'(count), 64'd3);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 64'(mem_req_valid), 64'd1);
        chk("arst_req_addr", mem_req_addr, RESET_PC);
        chk("arst_deq_valid", 64'(deq_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_deq_pc", deq_pc, 64'h0);
        chk("arst_deq_instr", 64'(deq_instr), 64'h0);
        s_deq_rdy = 1'b1;
        do_reset();
        chk("restart_addr", mem_req_addr, RESET_PC);
        steps(2);
        chk("restart_pc", deq_pc, 64'h0);
        steps(2);

        // Random ready, latency and occasional redirects.
        for (int i = 0; i < 1000; i++) begin
            s_mem_rdy = 1'($urandom_range(0, 1));
            s_deq_rdy = 1'($urandom_range(0, 1));
            s_lat     = $urandom_range(1, 3);
            s_redir   = ($urandom_range(0, 39) == 0);
            s_rpc     = 64'($urandom_range(0, 1023)) << 2;
            step();
        end
        s_redir = 1'b0;
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
